// File: rtl/dct_pkg.sv
// Shared types and helpers for the DCT block-fetch front end.
package dct_pkg;

   localparam int unsigned BLK       = 8;
   localparam int unsigned PIX_W_DEF = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_OUT,
      ST_DONE
   } fetch_state_e;

   // Raster address of pixel (bx*8+col, by*8+r).
   function automatic int unsigned pix_addr(input int unsigned base,
                                            input int unsigned img_w,
                                            input int unsigned bx,
                                            input int unsigned by,
                                            input int unsigned col,
                                            input int unsigned r);
      return base + (by * BLK + r) * img_w + bx * BLK + col;
   endfunction

endpackage

// File: rtl/dct_addr_gen.sv
// Row/column/block counters and the registered memory read address.
module dct_addr_gen
   import dct_pkg::*;
#(
   parameter int unsigned IMG_W     = 64,
   parameter int unsigned IMG_H     = 64,
   parameter int unsigned ADDR_W    = 15,
   parameter int unsigned BASE_ADDR = 2,
   parameter int unsigned BX_W      = 3,
   parameter int unsigned BY_W      = 3
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              row_step,
   input  logic              advance,
   output logic [2:0]        row,
   output logic [2:0]        col_idx,
   output logic [BX_W-1:0]   blk_x,
   output logic [BY_W-1:0]   blk_y,
   output logic              img_last,
   output logic              row_last_c,
   output logic [ADDR_W-1:0] mem_addr
);

   localparam int unsigned BX_MAX = IMG_W / BLK - 1;
   localparam int unsigned BY_MAX = IMG_H / BLK - 1;

   logic [2:0]        col_nxt;
   logic [BX_W-1:0]   bx_nxt;
   logic [BY_W-1:0]   by_nxt;
   logic              col_wrap;
   logic              bx_wrap;
   logic              last_nxt;
   logic [ADDR_W-1:0] addr_row_nxt;
   logic [ADDR_W-1:0] addr_adv_nxt;

   assign row_last_c = (row == 3'd7);

   // Next column position with block wrap, and the addresses that go with it.
   always_comb begin
      col_wrap = (col_idx == 3'd7);
      bx_wrap  = col_wrap && (blk_x == BX_W'(BX_MAX));
      col_nxt  = col_idx + 3'd1;
      bx_nxt   = blk_x;
      by_nxt   = blk_y;
      if (col_wrap)
         bx_nxt = bx_wrap ? '0 : blk_x + BX_W'(1);
      if (bx_wrap)
         by_nxt = (blk_y == BY_W'(BY_MAX)) ? '0 : blk_y + BY_W'(1);
      last_nxt = (col_nxt == 3'd7) && (bx_nxt == BX_W'(BX_MAX)) &&
                 (by_nxt == BY_W'(BY_MAX));
      addr_row_nxt = ADDR_W'(pix_addr(BASE_ADDR, IMG_W, 32'(blk_x), 32'(blk_y),
                                      32'(col_idx), 32'(row + 3'd1)));
      addr_adv_nxt = ADDR_W'(pix_addr(BASE_ADDR, IMG_W, 32'(bx_nxt), 32'(by_nxt),
                                      32'(col_nxt), 32'd0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row      <= '0;
         col_idx  <= '0;
         blk_x    <= '0;
         blk_y    <= '0;
         img_last <= 1'b0;
         mem_addr <= ADDR_W'(BASE_ADDR);
      end else if (clear) begin
         row      <= '0;
         col_idx  <= '0;
         blk_x    <= '0;
         blk_y    <= '0;
         img_last <= 1'b0;
         mem_addr <= ADDR_W'(BASE_ADDR);
      end else if (advance) begin
         row      <= '0;
         col_idx  <= col_nxt;
         blk_x    <= bx_nxt;
         blk_y    <= by_nxt;
         img_last <= last_nxt;
         mem_addr <= addr_adv_nxt;
      end else if (row_step) begin
         // Address stays on row 7 once the column has been fully presented.
         if (row_last_c) begin
            row <= '0;
         end else begin
            row      <= row + 3'd1;
            mem_addr <= addr_row_nxt;
         end
      end
   end

endmodule

// File: rtl/dct_block_fetch.sv
// Streams a raster image from block memory as 8x8 blocks, one column per beat.
module dct_block_fetch
   import dct_pkg::*;
#(
   parameter int unsigned IMG_W       = 64,
   parameter int unsigned IMG_H       = 64,
   parameter int unsigned PIX_W       = PIX_W_DEF,
   parameter int unsigned ADDR_W      = 15,
   parameter int unsigned BASE_ADDR   = 2,
   parameter bit          LEVEL_SHIFT = 1'b1,
   localparam int unsigned BX_W = (IMG_W / BLK > 1) ? $clog2(IMG_W / BLK) : 1,
   localparam int unsigned BY_W = (IMG_H / BLK > 1) ? $clog2(IMG_H / BLK) : 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [PIX_W-1:0]     mem_dout,
   output logic                 col_valid,
   input  logic                 col_ready,
   output logic [8*PIX_W-1:0]   col_data,
   output logic [2:0]           col_idx,
   output logic [BX_W-1:0]      blk_x,
   output logic [BY_W-1:0]      blk_y,
   output logic                 img_last
);

   localparam logic [PIX_W-1:0] HALF = {1'b1, {(PIX_W-1){1'b0}}};

   fetch_state_e     state, state_nxt;
   logic             clear_en;
   logic             row_step_en;
   logic             advance_en;
   logic             row_last;
   logic [2:0]       row;
   logic             cap_en_q;
   logic [2:0]       cap_row_q;
   logic [PIX_W-1:0] pix_cap;

   dct_addr_gen #(
      .IMG_W     (IMG_W),
      .IMG_H     (IMG_H),
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .BX_W      (BX_W),
      .BY_W      (BY_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear_en),
      .row_step   (row_step_en),
      .advance    (advance_en),
      .row        (row),
      .col_idx    (col_idx),
      .blk_x      (blk_x),
      .blk_y      (blk_y),
      .img_last   (img_last),
      .row_last_c (row_last),
      .mem_addr   (mem_addr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      clear_en    = 1'b0;
      row_step_en = 1'b0;
      advance_en  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               clear_en  = 1'b1;
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            row_step_en = 1'b1;
            if (row_last)
               state_nxt = ST_WAIT;
         end
         ST_WAIT: state_nxt = ST_OUT;
         ST_OUT: begin
            if (col_ready) begin
               advance_en = 1'b1;
               state_nxt  = img_last ? ST_DONE : ST_FETCH;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Handshake and status flags follow the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         col_valid <= 1'b0;
      end else begin
         busy      <= (state_nxt == ST_FETCH) || (state_nxt == ST_WAIT) ||
                      (state_nxt == ST_OUT);
         done      <= (state_nxt == ST_DONE);
         col_valid <= (state_nxt == ST_OUT);
      end
   end

   // Read data for a row arrives one cycle after its address.
   assign pix_cap = LEVEL_SHIFT ? (mem_dout - HALF) : mem_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_en_q  <= 1'b0;
         cap_row_q <= '0;
         col_data  <= '0;
      end else begin
         cap_en_q  <= (state == ST_FETCH);
         cap_row_q <= row;
         if (cap_en_q)
            col_data[32'(cap_row_q) * PIX_W +: PIX_W] <= pix_cap;
      end
   end

endmodule

// File: tb/tb_dct_block_fetch.sv
// Scoreboard bench for dct_block_fetch: full-image streaming, stalls, restart, reset, level shift.
module tb_dct_block_fetch;

   localparam int unsigned PW = 12;

   typedef struct {
      logic [8*PW-1:0] data;
      int              col;
      int              bx;
      int              by;
      bit              last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start, col_ready;
   logic            busy, done, col_valid, img_last;
   logic [14:0]     mem_addr;
   logic [PW-1:0]   mem_dout;
   logic [8*PW-1:0] col_data;
   logic [2:0]      col_idx;
   logic [2:0]      blk_x, blk_y;

   logic            start_l, col_ready_l;
   logic            busy_l, done_l, col_valid_l, img_last_l;
   logic [14:0]     mem_addr_l;
   logic [PW-1:0]   mem_dout_l, fill_l;
   logic [8*PW-1:0] col_data_l;
   logic [2:0]      col_idx_l;
   logic [0:0]      blk_x_l, blk_y_l;

   logic [PW-1:0]   mem0 [0:32767];
   beat_t           sb [$];
   int              n_checks = 0;
   int              n_err = 0;

   always #5 clk = ~clk;

   dct_block_fetch #(
      .IMG_W(64), .IMG_H(64), .PIX_W(PW), .ADDR_W(15), .BASE_ADDR(2), .LEVEL_SHIFT(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .col_valid(col_valid),
      .col_ready(col_ready), .col_data(col_data), .col_idx(col_idx),
      .blk_x(blk_x), .blk_y(blk_y), .img_last(img_last)
   );

   dct_block_fetch #(
      .IMG_W(16), .IMG_H(8), .PIX_W(PW), .ADDR_W(15), .BASE_ADDR(2), .LEVEL_SHIFT(1'b1)
   ) dut_ls (
      .clk(clk), .rst_n(rst_n), .start(start_l), .busy(busy_l), .done(done_l),
      .mem_addr(mem_addr_l), .mem_dout(mem_dout_l), .col_valid(col_valid_l),
      .col_ready(col_ready_l), .col_data(col_data_l), .col_idx(col_idx_l),
      .blk_x(blk_x_l), .blk_y(blk_y_l), .img_last(img_last_l)
   );

   // One-cycle-latency memories.
   always @(posedge clk) begin
      mem_dout   <= mem0[mem_addr];
      mem_dout_l <= fill_l;
   end

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_image();
      beat_t b;
      sb.delete();
      for (int by = 0; by < 8; by++)
         for (int bx = 0; bx < 8; bx++)
            for (int c = 0; c < 8; c++) begin
               b.data = '0;
               for (int r = 0; r < 8; r++)
                  b.data[r*PW +: PW] = PW'(((by*8 + r)*64 + bx*8 + c) % 4096);
               b.col  = c;
               b.bx   = bx;
               b.by   = by;
               b.last = (by == 7) && (bx == 7) && (c == 7);
               sb.push_back(b);
            end
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_busy"},      128'(busy), 128'(0));
      check_eq({tag, "_done"},      128'(done), 128'(0));
      check_eq({tag, "_valid"},     128'(col_valid), 128'(0));
      check_eq({tag, "_mem_addr"},  128'(mem_addr), 128'(2));
      check_eq({tag, "_col_data"},  128'(col_data), 128'(0));
      check_eq({tag, "_col_idx"},   128'(col_idx), 128'(0));
      check_eq({tag, "_blk_x"},     128'(blk_x), 128'(0));
      check_eq({tag, "_blk_y"},     128'(blk_y), 128'(0));
      check_eq({tag, "_img_last"},  128'(img_last), 128'(0));
   endtask

   // stall: random col_ready; restart_at: extra start cycle; rst_at: reset cycle (-1 = none)
   task automatic run_img(input bit stall, input int restart_at, input int rst_at);
      beat_t           e;
      int              nbeat = 0;
      bit              finished = 1'b0;
      bit              hold = 1'b0;
      bit              rdy;
      logic [8*PW-1:0] h_data;
      logic [2:0]      h_col, h_bx, h_by;
      logic            h_last;
      push_image();
      @(negedge clk);
      start = 1'b1;
      col_ready = 1'b1;
      for (int j = 1; j <= 30000 && !finished; j++) begin
         @(negedge clk);
         start = (j == restart_at);
         if (j == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_state("midreset");
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 20; k++) begin
               @(negedge clk);
               check_eq("post_reset_done", 128'(done), 128'(0));
               check_eq("post_reset_busy", 128'(busy), 128'(0));
            end
            finished = 1'b1;
         end else begin
            if (j == 1)
               check_eq("busy_rise", 128'(busy), 128'(1));
            if (!stall && j <= 8)
               check_eq("mem_addr_row", 128'(mem_addr), 128'(2 + (j-1)*64));
            if (hold) begin
               check_eq("hold_valid", 128'(col_valid), 128'(1));
               check_eq("hold_data", 128'(col_data), 128'(h_data));
               check_eq("hold_flags", 128'({col_idx, blk_x, blk_y, img_last}),
                        128'({h_col, h_bx, h_by, h_last}));
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            col_ready = rdy;
            hold   = col_valid && !rdy;
            h_data = col_data;
            h_col  = col_idx;
            h_bx   = blk_x;
            h_by   = blk_y;
            h_last = img_last;
            if (col_valid && rdy) begin
               if (sb.size() == 0) begin
                  check_eq("extra_beat", 128'(1), 128'(0));
               end else begin
                  e = sb.pop_front();
                  check_eq("col_data", 128'(col_data), 128'(e.data));
                  check_eq("col_idx", 128'(col_idx), 128'(e.col));
                  check_eq("blk_x", 128'(blk_x), 128'(e.bx));
                  check_eq("blk_y", 128'(blk_y), 128'(e.by));
                  check_eq("img_last", 128'(img_last), 128'(e.last));
                  if (e.last)
                     check_eq("last_beat_index", 128'(nbeat), 128'(511));
               end
               if (!stall)
                  check_eq("beat_cycle", 128'(j), 128'(10 + 10*nbeat));
               nbeat++;
            end
            if (done) begin
               if (!stall)
                  check_eq("done_cycle", 128'(j), 128'(5121));
               check_eq("beat_count", 128'(nbeat), 128'(512));
               check_eq("sb_empty", 128'(sb.size()), 128'(0));
               @(negedge clk);
               check_eq("done_pulse", 128'(done), 128'(0));
               check_eq("busy_after", 128'(busy), 128'(0));
               check_eq("valid_after", 128'(col_valid), 128'(0));
               finished = 1'b1;
            end
         end
      end
      if (!finished)
         check_eq("run_timeout", 128'(0), 128'(1));
      start = 1'b0;
   endtask

   task automatic run_ls(input logic [PW-1:0] fill, input logic [PW-1:0] exp);
      int nbeat = 0;
      bit finished = 1'b0;
      fill_l = fill;
      @(negedge clk);
      start_l = 1'b1;
      col_ready_l = 1'b1;
      for (int j = 1; j <= 500 && !finished; j++) begin
         @(negedge clk);
         start_l = 1'b0;
         if (col_valid_l) begin
            for (int r = 0; r < 8; r++)
               check_eq("ls_elem", 128'(col_data_l[r*PW +: PW]), 128'(exp));
            nbeat++;
         end
         if (done_l) begin
            check_eq("ls_beats", 128'(nbeat), 128'(16));
            finished = 1'b1;
         end
      end
      if (!finished)
         check_eq("ls_timeout", 128'(0), 128'(1));
   endtask

   initial begin
      for (int a = 0; a < 32768; a++)
         mem0[a] = '0;
      for (int a = 0; a < 4096; a++)
         mem0[a + 2] = PW'(a);
      rst_n = 1'b0;
      start = 1'b0;
      col_ready = 1'b0;
      start_l = 1'b0;
      col_ready_l = 1'b0;
      fill_l = '0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_img(1'b0, -1, -1);
      run_img(1'b1, -1, -1);
      run_img(1'b0, 300, -1);
      run_img(1'b0, -1, 15);
      run_img(1'b0, -1, -1);
      run_ls(12'h000, 12'h800);
      run_ls(12'hFFF, 12'h7FF);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/dct_block_fetch.md
# dct_block_fetch

Upstream feeder for the OBC DCT datapath. Reads a raster-ordered greyscale image from single-port block memory with one cycle of read latency. Reorders the pixels into 8×8 blocks and streams each block as eight column vectors of eight pixels over a valid/ready handshake. This replaces ad-hoc pixel-to-matrix loading and gives the CX stage one column (X[0..7]) per beat.

## Interface
Parameters:
- IMG_W, 64, image width in pixels; must be a multiple of 8
- IMG_H, 64, image height in pixels; must be a multiple of 8
- PIX_W, 12, pixel width
- ADDR_W, 15, memory address width; BASE_ADDR+IMG_W*IMG_H-1 must fit
- BASE_ADDR, 2, address of pixel (0,0)
- LEVEL_SHIFT, 1, when 1 the block subtracts 2^(PIX_W-1) and outputs are two's complement

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to stream the whole image; ignored unless idle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final column is accepted
- mem_addr  out  ADDR_W  registered read address
- mem_dout  in  PIX_W  read data, valid the cycle after the address is presented
- col_valid  out  1  column beat available
- col_ready  in  1  consumer accepts the beat
- col_data  out  8*PIX_W  row r at bits [r*PIX_W +: PIX_W]
- col_idx  out  3  column within the block (0..7)
- blk_x  out  clog2(IMG_W/8)  block column index
- blk_y  out  clog2(IMG_H/8)  block row index
- img_last  out  1  beat is column 7 of the final block

## Operation
- States: IDLE → FETCH → WAIT → OUT → (FETCH | DONE) → IDLE.
- IDLE:
  - If start=1, clear all counters, load mem_addr with the address of (0,0), and go to FETCH.
- FETCH:
  - Lasts 8 cycles.
  - Row counter r runs 0..7.
  - mem_addr = BASE_ADDR + (blk_y*8+r)*IMG_W + blk_x*8 + col_idx.
- Capture:
  - mem_dout is registered into assembly slot r one cycle after that row's address.
  - With LEVEL_SHIFT=1, the slot holds mem_dout − 2^(PIX_W−1) as a PIX_W-bit two's complement value (range −2048..2047 for PIX_W=12).
- WAIT: one cycle that captures the row-7 data.
- OUT:
  - col_valid=1.
  - col_data, col_idx, blk_x, blk_y and img_last are held stable until col_valid && col_ready.
- Advance on accept:
  - col_idx increments.
  - On col_idx wrap 7→0, blk_x increments.
  - On blk_x wrap, blk_y increments.
  - If img_last, go to DONE; otherwise go to FETCH with the new address.
- DONE: done=1 for one cycle, busy drops, then IDLE.
- Block order: blocks in raster order (blk_y outer, blk_x inner); columns 0..7 within a block; rows 0..7 within a column.
- start asserted while busy has no effect.
- col_ready is ignored outside OUT.

## Timing
- Reset values: busy=0, done=0, col_valid=0, mem_addr=BASE_ADDR, col_data=0, col_idx=0, blk_x=0, blk_y=0, img_last=0.
- Cycle 0: start sampled.
- Cycles 1..8: mem_addr presents rows 0..7.
- Cycles 2..9: data captured.
- Cycle 10: first col_valid=1.
- Each beat costs 10 cycles with col_ready held high: 8 FETCH + 1 WAIT + 1 OUT.
- Backpressure: each cycle of col_ready=0 in OUT adds one cycle; the next FETCH starts the cycle after acceptance.
- Full 64×64 image: 512 beats, 5120 cycles; done pulses at cycle 5121 with no stalls.
- rst_n low at any time, including mid-FETCH or mid-OUT:
  - All outputs return to reset values asynchronously.
  - The partial column is discarded.
  - No done pulse is issued.

## Structure
- Shared package dct_pkg holds:
  - BLK=8
  - default PIX_W
  - the fetch-state enum (IDLE, FETCH, WAIT, OUT, DONE)
  - a function computing the pixel address from blk_x, blk_y, col_idx and r
- One sub-module is natural: dct_addr_gen, containing the r/col_idx/blk_x/blk_y counters, the wrap logic, img_last and the registered mem_addr.
- The top module keeps the FSM, the assembly register and the handshake.

## Test plan
- Memory model preload: pixel(x,y) = (y*64+x) mod 4096 at BASE_ADDR=2, LEVEL_SHIFT=0, col_ready=1.
  - The first beat appears at cycle 10: col_data rows = {0,64,128,…,448}, col_idx=0, blk_x=0, blk_y=0.
  - done pulses at cycle 5121.
- Same image: the beat with blk_x=7, blk_y=7, col_idx=7 has img_last=1.
  - Its row 0 = 56*64+63 = 3647.
  - It is the 512th beat.
- LEVEL_SHIFT=1 with all pixels 0 → every element = 0x800 (−2048).
- LEVEL_SHIFT=1 with all pixels 4095 → every element = 0x7FF.
- Random col_ready (50%):
  - col_data and flags stay stable while col_valid && !col_ready.
  - The beat sequence is identical to the no-stall run.
- start pulsed at cycle 300 while busy → no restart and unchanged beat sequence.
- rst_n low at cycle 15 (mid-FETCH) → all outputs reach reset values immediately, busy=0, no done; a new start reproduces the first beat exactly.
